rf_wb_arbiter: RTL and testbench



---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_wb_arbiter_fifo.sv | 70 +++++++
 rtl/rf_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the register-file writeback path.
package rf_pkg;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 1 << AW;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    // Expand a register address into a one-hot register mask.
    function automatic logic [NREG-1:0] onehot_reg(input logic [AW-1:0] addr);
        logic [NREG-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// wb_fifo: circular buffer with up to two enqueues and two dequeues per cycle.
// The producer only pushes when at least two slots are free, so there is no
// overflow check here.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    enq_n,
    input  wb_entry_t                     enq_a,
    input  wb_entry_t                     enq_b,
    input  logic [1:0]                    deq_n,
    output wb_entry_t                     head,
    output wb_entry_t                     second,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][AW-1:0]      entry_addr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t          mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [DEPTH-1:0]   valid_next;

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + PW'(1)];

    // Expose per-slot destination addresses for the pending-register map.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

    // Retire dequeued slots, then mark freshly written slots valid.
    always_comb begin
        valid_next = entry_valid;
        if (deq_n != 2'd0) valid_next[rd_ptr] = 1'b0;
        if (deq_n == 2'd2) valid_next[rd_ptr + PW'(1)] = 1'b0;
        if (enq_n != 2'd0) valid_next[wr_ptr] = 1'b1;
        if (enq_n == 2'd2) valid_next[wr_ptr + PW'(1)] = 1'b1;
    end

    // Payload storage; contents are qualified by entry_valid so no reset.
    always_ff @(posedge clk) begin
        if (enq_n != 2'd0) mem[wr_ptr] <= enq_a;
        if (enq_n == 2'd2) mem[wr_ptr + PW'(1)] <= enq_b;
    end

    // Pointers, occupancy and slot-valid flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            rd_ptr      <= rd_ptr + PW'(deq_n);
            wr_ptr      <= wr_ptr + PW'(enq_n);
            count       <= count + CW'(enq_n) - CW'(deq_n);
            entry_valid <= valid_next;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU, LSU and MUL results onto the two RF write ports.
// Port 2 always carries the younger write. Define WB_BYPASS_EN to let LSU/MUL
// results skip the empty FIFO and take a free port in the handshake cycle.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_addr,
    input  logic [DW-1:0]              alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [AW-1:0]              lsu_addr,
    input  logic [DW-1:0]              lsu_data,
    input  logic                       mul_valid,
    output logic                       mul_ready,
    input  logic [AW-1:0]              mul_addr,
    input  logic [DW-1:0]              mul_data,
    output logic                       we,
    output logic [AW-1:0]              waddr,
    output logic [DW-1:0]              wdata,
    output logic                       we2,
    output logic [AW-1:0]              waddr2,
    output logic [DW-1:0]              wdata2,
    output logic [NREG-1:0]            busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_entry_t              alu_e;
    wb_entry_t              lsu_e;
    wb_entry_t              mul_e;
    wb_entry_t              head;
    wb_entry_t              second;
    wb_entry_t              p1;
    wb_entry_t              p2;
    wb_entry_t              enq_a;
    wb_entry_t              enq_b;
    logic                   p1_v;
    logic                   p2_v;
    logic [CW-1:0]          count;
    logic                   ready;
    logic                   lsu_hs;
    logic                   mul_hs;
    logic                   lsu_enq;
    logic                   mul_enq;
    logic [1:0]             enq_n;
    logic [1:0]             deq_n;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH-1:0][AW-1:0] entry_addr;

    assign alu_e = '{addr: alu_addr, data: alu_data};
    assign lsu_e = '{addr: lsu_addr, data: lsu_data};
    assign mul_e = '{addr: mul_addr, data: mul_data};

    // Ready comes from registered occupancy only; leaves room for two pushes.
    assign ready     = (count <= CW'(DEPTH - 2));
    assign lsu_ready = ready;
    assign mul_ready = ready;
    assign lsu_hs    = lsu_valid & ready;
    assign mul_hs    = mul_valid & ready;

    // Port selection in age order: FIFO head, FIFO second, then ALU.
    always_comb begin
        p1_v    = 1'b0;
        p1      = alu_e;
        p2_v    = 1'b0;
        p2      = alu_e;
        deq_n   = 2'd0;
        lsu_enq = lsu_hs;
        mul_enq = mul_hs;
        if (count != '0) begin
            p1_v  = 1'b1;
            p1    = head;
            deq_n = 2'd1;
            if (alu_valid) begin
                p2_v = 1'b1;
                p2   = alu_e;
            end else if (count >= CW'(2)) begin
                p2_v  = 1'b1;
                p2    = second;
                deq_n = 2'd2;
            end
        end else begin
            if (alu_valid) begin
                p1_v = 1'b1;
                p1   = alu_e;
            end
`ifdef WB_BYPASS_EN
            // Empty FIFO: LSU then MUL take whatever ports the ALU left free.
            if (lsu_hs) begin
                lsu_enq = 1'b0;
                if (!p1_v) begin
                    p1_v = 1'b1;
                    p1   = lsu_e;
                end else begin
                    p2_v = 1'b1;
                    p2   = lsu_e;
                end
            end
            if (mul_hs) begin
                if (!p1_v) begin
                    p1_v    = 1'b1;
                    p1      = mul_e;
                    mul_enq = 1'b0;
                end else if (!p2_v) begin
                    p2_v    = 1'b1;
                    p2      = mul_e;
                    mul_enq = 1'b0;
                end
            end
`endif
        end
    end

    // Pack surviving handshakes at the tail, LSU ahead of MUL.
    always_comb begin
        enq_n = {1'b0, lsu_enq} + {1'b0, mul_enq};
        enq_a = lsu_enq ? lsu_e : mul_e;
        enq_b = mul_e;
    end

    // Write ports are silenced for the whole reset pulse.
    assign we         = p1_v & ~rst;
    assign waddr      = p1.addr;
    assign wdata      = p1.data;
    assign we2        = p2_v & ~rst;
    assign waddr2     = p2.addr;
    assign wdata2     = p2.data;
    assign fifo_count = count;

    // Pending-register map over buffered entries only.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) busy = busy | onehot_reg(entry_addr[i]);
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .enq_n       (enq_n),
        .enq_a       (enq_a),
        .enq_b       (enq_b),
        .deq_n       (deq_n),
        .head        (head),
        .second      (second),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter with a shadow register file.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic            clk;
    logic            rst;
    logic            alu_valid;
    logic [AW-1:0]   alu_addr;
    logic [DW-1:0]   alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_addr;
    logic [DW-1:0]   lsu_data;
    logic            mul_valid;
    logic            mul_ready;
    logic [AW-1:0]   mul_addr;
    logic [DW-1:0]   mul_data;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            we2;
    logic [AW-1:0]   waddr2;
    logic [DW-1:0]   wdata2;
    logic [NREG-1:0] busy;
    logic [2:0]      fifo_count;

    int checks;
    int errors;
    logic [DW-1:0] rf_shadow [NREG];

    rf_wb_arbiter #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .mul_valid  (mul_valid),
        .mul_ready  (mul_ready),
        .mul_addr   (mul_addr),
        .mul_data   (mul_data),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .we2        (we2),
        .waddr2     (waddr2),
        .wdata2     (wdata2),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file as seen through the write ports; port 2 applied last.
    always @(posedge clk) begin
        if (!rst) begin
            if (we)  rf_shadow[waddr]  <= wdata;
            if (we2) rf_shadow[waddr2] <= wdata2;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_srcs(input logic av, input int aa, input int ad,
                            input logic lv, input int la, input int ld,
                            input logic mv, input int ma, input int md);
        alu_valid = av; alu_addr = AW'(aa); alu_data = DW'(ad);
        lsu_valid = lv; lsu_addr = AW'(la); lsu_data = DW'(ld);
        mul_valid = mv; mul_addr = AW'(ma); mul_data = DW'(md);
    endtask

    task automatic exp_ports(input string tag,
                             input logic e1, input int a1, input int d1,
                             input logic e2, input int a2, input int d2);
        chk({tag, "_we"}, 64'(we), 64'(e1));
        if (e1) begin
            chk({tag, "_waddr"}, 64'(waddr), 64'(a1));
            chk({tag, "_wdata"}, 64'(wdata), 64'(d1));
        end
        chk({tag, "_we2"}, 64'(we2), 64'(e2));
        if (e2) begin
            chk({tag, "_waddr2"}, 64'(waddr2), 64'(a2));
            chk({tag, "_wdata2"}, 64'(wdata2), 64'(d2));
        end
    endtask

    // Advance to the low phase, apply inputs, settle before checking.
    task automatic cyc(input logic av, input int aa, input int ad,
                       input logic lv, input int la, input int ld,
                       input logic mv, input int ma, input int md);
        @(negedge clk);
        set_srcs(av, aa, ad, lv, la, ld, mv, ma, md);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_srcs(1, 1, 'h1, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_we2", 64'(we2), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_srcs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("rst_mul_ready", 64'(mul_ready), 64'd1);

`ifndef WB_BYPASS_EN
        // ALU only: same-cycle write on port 1
        cyc(1, 5, 'h1234, 0, 0, 0, 0, 0, 0);
        exp_ports("alu", 1, 5, 'h1234, 0, 0, 0);

        // LSU and MUL to r3 in one cycle, written next cycle in age order
        cyc(0, 0, 0, 1, 3, 'hAA, 1, 3, 'hBB);
        chk("lm_ready", 64'(lsu_ready), 64'd1);
        exp_ports("lm_acc", 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lm_count", 64'(fifo_count), 64'd2);
        chk("lm_busy", 64'(busy), 64'h8);
        exp_ports("lm_wr", 1, 3, 'hAA, 1, 3, 'hBB);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lm_count0", 64'(fifo_count), 64'd0);
        chk("lm_r3", 64'(rf_shadow[3]), 64'hBB);
        chk("alu_r5", 64'(rf_shadow[5]), 64'h1234);

        // Buffered r7 ahead of same-cycle ALU r7
        cyc(0, 0, 0, 1, 7, 'h11, 0, 0, 0);
        cyc(1, 7, 'h22, 0, 0, 0, 0, 0, 0);
        chk("r7_busy_pre", 64'(busy), 64'h80);
        chk("r7_count", 64'(fifo_count), 64'd1);
        exp_ports("r7", 1, 7, 'h11, 1, 7, 'h22);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r7_busy_post", 64'(busy), 64'd0);
        chk("r7_final", 64'(rf_shadow[7]), 64'h22);

        // Sustained LSU+MUL pressure with ALU every cycle
        cyc(1, 20, 'hA0, 1, 10, 'hC0, 1, 14, 'hD0);
        chk("p0_ready", 64'(lsu_ready), 64'd1);
        exp_ports("p0", 1, 20, 'hA0, 0, 0, 0);
        cyc(1, 21, 'hA1, 1, 11, 'hC1, 1, 15, 'hD1);
        chk("p1_count", 64'(fifo_count), 64'd2);
        chk("p1_ready", 64'(mul_ready), 64'd1);
        exp_ports("p1", 1, 10, 'hC0, 1, 21, 'hA1);
        cyc(1, 22, 'hA2, 1, 12, 'hC2, 1, 16, 'hD2);
        chk("p2_count", 64'(fifo_count), 64'd3);
        chk("p2_ready", 64'(lsu_ready), 64'd0);
        exp_ports("p2", 1, 14, 'hD0, 1, 22, 'hA2);
        cyc(1, 23, 'hA3, 1, 12, 'hC2, 1, 16, 'hD2);
        chk("p3_count", 64'(fifo_count), 64'd2);
        chk("p3_ready", 64'(lsu_ready), 64'd1);
        exp_ports("p3", 1, 11, 'hC1, 1, 23, 'hA3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("p4_count", 64'(fifo_count), 64'd3);
        chk("p4_busy", 64'(busy), 64'h0001_9000);
        exp_ports("p4", 1, 15, 'hD1, 1, 12, 'hC2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("p5_count", 64'(fifo_count), 64'd1);
        exp_ports("p5", 1, 16, 'hD2, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("p6_count", 64'(fifo_count), 64'd0);
        chk("p6_busy", 64'(busy), 64'd0);
        chk("p6_r12", 64'(rf_shadow[12]), 64'hC2);
        chk("p6_r16", 64'(rf_shadow[16]), 64'hD2);

        // Reset with three entries queued and an ALU result in flight
        cyc(1, 1, 'h1, 1, 2, 'h2, 1, 4, 'h4);
        cyc(1, 1, 'h1, 1, 2, 'h2, 1, 4, 'h4);
        cyc(1, 1, 'h1, 0, 0, 0, 0, 0, 0);
        chk("mr_count3", 64'(fifo_count), 64'd3);
        rst = 1'b1;
        #1;
        chk("mr_we", 64'(we), 64'd0);
        chk("mr_we2", 64'(we2), 64'd0);
        chk("mr_count", 64'(fifo_count), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_srcs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mr_ready", 64'(lsu_ready), 64'd1);
        chk("mr_count_after", 64'(fifo_count), 64'd0);
`else
        // Empty FIFO: LSU result bypasses to port 1
        cyc(0, 0, 0, 1, 9, 'h55, 0, 0, 0);
        exp_ports("bp_lsu", 1, 9, 'h55, 0, 0, 0);
        chk("bp_count", 64'(fifo_count), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bp_count_after", 64'(fifo_count), 64'd0);
        chk("bp_r9", 64'(rf_shadow[9]), 64'h55);

        // ALU and LSU take both ports; MUL is buffered
        cyc(1, 2, 'h77, 1, 3, 'h88, 1, 4, 'h99);
        exp_ports("bp_three", 1, 2, 'h77, 1, 3, 'h88);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bp_mul_count", 64'(fifo_count), 64'd1);
        chk("bp_mul_busy", 64'(busy), 64'h10);
        exp_ports("bp_mul", 1, 4, 'h99, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bp_drain", 64'(fifo_count), 64'd0);
        chk("bp_r4", 64'(rf_shadow[4]), 64'h99);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
